// File: rtl/dp_operand_loader.sv
// dp_operand_loader: packs streamed pixel/weight pairs for the dot-product engine, runs it and returns its result
// Ports: clk; GlobalReset (async, active-low); in_valid/in_ready/in_pixel/in_weight/in_last pair stream;
//        Pixels/Weights packed slot buses (slot k at k*width); dp_clear/dp_value engine interface;
//        res_valid/res_ready/res_value result stream.
// Optional: define LOADER_ZERO_PAD_EN to let in_last end a vector early, zeroing the remaining slots.
module dp_operand_loader #(
    parameter int PIXEL_N     = 10,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int CLR_CYCLES  = 2,
    parameter int DP_CYCLES   = 120
) (
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PIXEL_SIZE-1:0]          in_pixel,
    input  logic [WEIGHT_SIZE-1:0]         in_weight,
    input  logic                           in_last,
    output logic [PIXEL_N*PIXEL_SIZE-1:0]  Pixels,
    output logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
    output logic                           dp_clear,
    input  logic [VAL_SIZE-1:0]            dp_value,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [VAL_SIZE-1:0]            res_value
);
    localparam int IW = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
    localparam int CW = $clog2(CLR_CYCLES + DP_CYCLES + 1);
    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
    state_t state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic done;
`ifdef LOADER_ZERO_PAD_EN
    assign done = in_last || idx == IW'(PIXEL_N - 1);
`else
    logic unused_last;
    assign unused_last = in_last;
    assign done = idx == IW'(PIXEL_N - 1);
`endif
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state     <= FILL;
            idx       <= '0;
            cnt       <= '0;
            Pixels    <= '0;
            Weights   <= '0;
            in_ready  <= 1'b0;
            dp_clear  <= 1'b1;
            res_valid <= 1'b0;
            res_value <= '0;
        end else begin
            case (state)
                FILL: begin
                    // in_ready is low in FILL only on the first edge after reset (or a bad-state recovery)
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                        dp_clear <= 1'b0;
                    end else if (in_valid) begin
                        for (int k = 0; k < PIXEL_N; k++) begin
                            if (k == int'(idx)) begin
                                Pixels[k*PIXEL_SIZE +: PIXEL_SIZE]    <= in_pixel;
                                Weights[k*WEIGHT_SIZE +: WEIGHT_SIZE] <= in_weight;
                            end
`ifdef LOADER_ZERO_PAD_EN
                            else if (in_last && k > int'(idx)) begin
                                Pixels[k*PIXEL_SIZE +: PIXEL_SIZE]    <= '0;
                                Weights[k*WEIGHT_SIZE +: WEIGHT_SIZE] <= '0;
                            end
`endif
                        end
                        if (done) begin
                            in_ready <= 1'b0;
                            dp_clear <= 1'b1;
                            cnt      <= '0;
                            idx      <= '0;
                            state    <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // one counter spans the clear window and the compute window
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CLR_CYCLES - 1))
                        dp_clear <= 1'b0;
                    if (cnt == CW'(CLR_CYCLES + DP_CYCLES - 1)) begin
                        res_value <= dp_value;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state     <= FILL;
                    idx       <= '0;
                    in_ready  <= 1'b0;
                    dp_clear  <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
